// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a memory
// watchdog, sticky error flags and a retired-instruction counter.
module mc_control_unit #(
  parameter logic [6:0] ITYPE   = 7'b0010011,
  parameter logic [6:0] J_ITYPE = 7'b1100111,
  parameter logic [6:0] RTYPE   = 7'b0110011,
  parameter logic [6:0] BTYPE   = 7'b1100011,
  parameter logic [6:0] UTYPE   = 7'b0010111,
  parameter logic [6:0] LTYPE   = 7'b0000011,
  parameter logic [6:0] STYPE   = 7'b0100011,
  parameter logic [6:0] JTYPE   = 7'b1101111,
  parameter logic [6:0] LUI     = 7'b0110111,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [6:0]  alu_opcode,
  output logic        aluout_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        illegal_instr,
  output logic        bus_error,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d, nxt;
  logic [WW-1:0]   wait_q, wait_d;
  logic            illegal_q, illegal_d, buserr_q, buserr_d;
  logic [31:0]     instret_q, instret_d;

  logic            req_c, we_c, addr_c, ir_c, pc_c, aluout_c, rf_c;
  logic [1:0]      a_c, b_c, wb_c;
  logic [6:0]      op_c;
  logic            known, waiting, expire, retire;

  always_comb begin
    known = opcode inside {ITYPE, J_ITYPE, RTYPE, BTYPE, UTYPE, LTYPE, STYPE, JTYPE, LUI};
  end

  always_comb begin
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = 1'b0;
    ir_c     = 1'b0;
    pc_c     = 1'b0;
    aluout_c = 1'b0;
    rf_c     = 1'b0;
    a_c      = 2'b00;
    b_c      = 2'b00;
    wb_c     = 2'b00;
    op_c     = UTYPE;
    nxt      = state_q;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        a_c   = 2'b10;
        b_c   = 2'b10;
        if (mem_ready) begin
          ir_c = 1'b1;
          pc_c = 1'b1;
          nxt  = S_DECODE;
        end
      end
      S_DECODE: nxt = known ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (opcode == RTYPE) begin
          op_c = opcode; aluout_c = 1'b1; nxt = S_WRITEBACK;
        end else if (opcode == ITYPE) begin
          op_c = opcode; b_c = 2'b01; aluout_c = 1'b1; nxt = S_WRITEBACK;
        end else if (opcode == UTYPE) begin
          a_c = 2'b01; b_c = 2'b01; aluout_c = 1'b1; nxt = S_WRITEBACK;
        end else if (opcode == LUI) begin
          a_c = 2'b11; b_c = 2'b01; aluout_c = 1'b1; nxt = S_WRITEBACK;
        end else if (opcode == LTYPE || opcode == STYPE) begin
          op_c = opcode; b_c = 2'b01; aluout_c = 1'b1; nxt = S_MEMORY;
        end else if (opcode == BTYPE) begin
          a_c = 2'b01; b_c = 2'b01; pc_c = branch_taken; nxt = S_FETCH;
        end else if (opcode == JTYPE || opcode == J_ITYPE) begin
          // Link value is the already-advanced PC, written before PC takes the target.
          op_c = opcode;
          a_c  = (opcode == JTYPE) ? 2'b01 : 2'b00;
          b_c  = 2'b01;
          pc_c = 1'b1;
          rf_c = 1'b1;
          wb_c = 2'b10;
          nxt  = S_FETCH;
        end else begin
          nxt = S_TRAP;
        end
      end
      S_MEMORY: begin
        req_c  = 1'b1;
        addr_c = 1'b1;
        we_c   = (opcode == STYPE);
        if (mem_ready) nxt = (opcode == STYPE) ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_c = 1'b1;
        wb_c = (opcode == LTYPE) ? 2'b01 : 2'b00;
        nxt  = S_FETCH;
      end
      default: nxt = S_TRAP;
    endcase
  end

  // A ready on the would-be expiry cycle is not a wait cycle, so it completes normally.
  always_comb begin
    waiting   = req_c && !mem_ready;
    expire    = (MEM_TIMEOUT != 0) && waiting && (wait_q == WAIT_LAST);
    state_d   = expire ? S_TRAP : nxt;
    retire    = (state_d == S_FETCH) &&
                (state_q inside {S_EXECUTE, S_MEMORY, S_WRITEBACK});
    instret_d = instret_q + 32'(retire);
    illegal_d = illegal_q | ((state_q == S_DECODE) && !known);
    buserr_d  = buserr_q | expire;
    if (state_d != state_q)
      wait_d = '0;
    else if (waiting && MEM_TIMEOUT != 0)
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      buserr_q  <= buserr_d;
      instret_q <= instret_d;
    end
  end

  assign mem_req       = req_c & ~rst;
  assign mem_we        = we_c & ~rst;
  assign addr_sel      = addr_c;
  assign ir_we         = ir_c & ~rst;
  assign pc_we         = pc_c & ~rst;
  assign aluout_we     = aluout_c & ~rst;
  assign rf_we         = rf_c & ~rst;
  assign alu_a_sel     = a_c;
  assign alu_b_sel     = b_c;
  assign alu_opcode    = op_c;
  assign wb_sel        = rst ? 2'b00 : wb_c;
  assign state_o       = state_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = buserr_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class and the trap paths.
module tb_mc_control_unit;
  localparam logic [6:0] ITYPE = 7'b0010011, J_ITYPE = 7'b1100111, RTYPE = 7'b0110011;
  localparam logic [6:0] BTYPE = 7'b1100011, UTYPE = 7'b0010111, LTYPE = 7'b0000011;
  localparam logic [6:0] STYPE = 7'b0100011, JTYPE = 7'b1101111, LUI = 7'b0110111;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic branch_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, aluout_we, rf_we, illegal_instr, bus_error;
  logic [1:0] alu_a_sel, alu_b_sel, wb_sel;
  logic [6:0] alu_opcode;
  logic [2:0] state_o;
  logic [31:0] instret;
  int checks = 0, errors = 0;

  mc_control_unit #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_opcode(alu_opcode), .aluout_we(aluout_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .state_o(state_o), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0;
    step(); step();
    rst = 1'b0; #1;
  endtask

  // Zero-wait fetch followed by decode; leaves the DUT in EXECUTE.
  task automatic fetch_decode(input logic [6:0] op);
    opcode = op; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1;
    step(); step();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_o); end
    checks++; if (mem_req !== 1'b0 || ir_we !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL rst_strobes got req=%b ir=%b pc=%b exp 0", mem_req, ir_we, pc_we); end
    checks++; if (instret !== 32'd0 || illegal_instr !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL rst_flags got ir=%0d ill=%b be=%b exp 0", instret, illegal_instr, bus_error); end
    rst = 1'b0; mem_ready = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || addr_sel !== 1'b0) begin errors++; $display("FAIL first_req got req=%b as=%b exp 1 0", mem_req, addr_sel); end
  endtask

  task automatic test_addi();
    opcode = ITYPE; mem_ready = 1'b1; #1;
    checks++; if (state_o !== 3'd0 || pc_we !== 1'b1 || ir_we !== 1'b1) begin errors++; $display("FAIL addi_fetch got st=%0d pc=%b ir=%b exp 0 1 1", state_o, pc_we, ir_we); end
    checks++; if (alu_a_sel !== 2'b10 || alu_b_sel !== 2'b10 || alu_opcode !== UTYPE) begin errors++; $display("FAIL addi_fetch_alu got a=%b b=%b op=%b", alu_a_sel, alu_b_sel, alu_opcode); end
    step(); mem_ready = 1'b0; #1;
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL addi_decode got %0d exp 1", state_o); end
    step();
    checks++; if (state_o !== 3'd2 || aluout_we !== 1'b1 || alu_a_sel !== 2'b00 || alu_b_sel !== 2'b01 || alu_opcode !== ITYPE) begin errors++; $display("FAIL addi_exec got st=%0d aw=%b a=%b b=%b op=%b", state_o, aluout_we, alu_a_sel, alu_b_sel, alu_opcode); end
    step();
    checks++; if (state_o !== 3'd4 || rf_we !== 1'b1 || wb_sel !== 2'b00) begin errors++; $display("FAIL addi_wb got st=%0d rf=%b wb=%b exp 4 1 00", state_o, rf_we, wb_sel); end
    step();
    checks++; if (state_o !== 3'd0 || instret !== 32'd1) begin errors++; $display("FAIL addi_retire got st=%0d instret=%0d exp 0 1", state_o, instret); end
  endtask

  task automatic test_load();
    fetch_decode(LTYPE);
    checks++; if (state_o !== 3'd2 || aluout_we !== 1'b1 || alu_b_sel !== 2'b01) begin errors++; $display("FAIL lw_exec got st=%0d aw=%b b=%b", state_o, aluout_we, alu_b_sel); end
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      checks++; if (state_o !== 3'd3 || mem_req !== 1'b1 || addr_sel !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lw_mem cycle %0d got st=%0d req=%b as=%b we=%b exp 3 1 1 0", i, state_o, mem_req, addr_sel, mem_we); end
      step();
    end
    mem_ready = 1'b0; #1;
    checks++; if (state_o !== 3'd4 || wb_sel !== 2'b01 || rf_we !== 1'b1) begin errors++; $display("FAIL lw_wb got st=%0d wb=%b rf=%b exp 4 01 1", state_o, wb_sel, rf_we); end
    step();
    checks++; if (state_o !== 3'd0 || instret !== 32'd2) begin errors++; $display("FAIL lw_retire got st=%0d instret=%0d exp 0 2", state_o, instret); end
  endtask

  task automatic test_store();
    fetch_decode(STYPE);
    step(); mem_ready = 1'b1; #1;
    checks++; if (state_o !== 3'd3 || mem_we !== 1'b1 || addr_sel !== 1'b1) begin errors++; $display("FAIL sw_mem got st=%0d we=%b as=%b exp 3 1 1", state_o, mem_we, addr_sel); end
    step(); mem_ready = 1'b0; #1;
    checks++; if (state_o !== 3'd0 || instret !== 32'd3) begin errors++; $display("FAIL sw_retire got st=%0d instret=%0d exp 0 3", state_o, instret); end
  endtask

  task automatic test_branch();
    fetch_decode(BTYPE);
    branch_taken = 1'b0; #1;
    checks++; if (state_o !== 3'd2 || pc_we !== 1'b0) begin errors++; $display("FAIL beq_nt got st=%0d pc=%b exp 2 0", state_o, pc_we); end
    step();
    checks++; if (state_o !== 3'd0 || instret !== 32'd4) begin errors++; $display("FAIL beq_nt_retire got st=%0d instret=%0d exp 0 4", state_o, instret); end
    fetch_decode(BTYPE);
    branch_taken = 1'b1; #1;
    checks++; if (pc_we !== 1'b1 || alu_a_sel !== 2'b01 || alu_b_sel !== 2'b01 || alu_opcode !== UTYPE) begin errors++; $display("FAIL beq_t got pc=%b a=%b b=%b op=%b", pc_we, alu_a_sel, alu_b_sel, alu_opcode); end
    step(); branch_taken = 1'b0;
    checks++; if (state_o !== 3'd0 || instret !== 32'd5) begin errors++; $display("FAIL beq_t_retire got st=%0d instret=%0d exp 0 5", state_o, instret); end
  endtask

  task automatic test_jumps();
    fetch_decode(JTYPE);
    checks++; if (pc_we !== 1'b1 || rf_we !== 1'b1 || wb_sel !== 2'b10 || alu_a_sel !== 2'b01 || alu_opcode !== JTYPE) begin errors++; $display("FAIL jal_exec got pc=%b rf=%b wb=%b a=%b op=%b", pc_we, rf_we, wb_sel, alu_a_sel, alu_opcode); end
    step();
    checks++; if (state_o !== 3'd0 || instret !== 32'd6) begin errors++; $display("FAIL jal_retire got st=%0d instret=%0d exp 0 6", state_o, instret); end
    fetch_decode(J_ITYPE);
    checks++; if (alu_a_sel !== 2'b00 || alu_opcode !== J_ITYPE || wb_sel !== 2'b10 || pc_we !== 1'b1) begin errors++; $display("FAIL jalr_exec got a=%b op=%b wb=%b pc=%b", alu_a_sel, alu_opcode, wb_sel, pc_we); end
    step();
    fetch_decode(LUI);
    checks++; if (alu_a_sel !== 2'b11 || alu_b_sel !== 2'b01 || alu_opcode !== UTYPE || aluout_we !== 1'b1) begin errors++; $display("FAIL lui_exec got a=%b b=%b op=%b aw=%b", alu_a_sel, alu_b_sel, alu_opcode, aluout_we); end
    step(); step();
    checks++; if (state_o !== 3'd0 || instret !== 32'd8) begin errors++; $display("FAIL lui_retire got st=%0d instret=%0d exp 0 8", state_o, instret); end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; mem_ready = 1'b1;
    step(); step();
    checks++; if (state_o !== 3'd7 || illegal_instr !== 1'b1) begin errors++; $display("FAIL ill_trap got st=%0d ill=%b exp 7 1", state_o, illegal_instr); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b0 || pc_we !== 1'b0 || instret !== 32'd8) begin errors++; $display("FAIL ill_hold cycle %0d got req=%b pc=%b instret=%0d exp 0 0 8", i, mem_req, pc_we, instret); end
      step();
    end
    do_reset();
    checks++; if (state_o !== 3'd0 || illegal_instr !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL ill_reset got st=%0d ill=%b instret=%0d exp 0 0 0", state_o, illegal_instr, instret); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 15; i++) step();
    checks++; if (state_o !== 3'd0 || mem_req !== 1'b1 || bus_error !== 1'b0) begin errors++; $display("FAIL wd_pre got st=%0d req=%b be=%b exp 0 1 0", state_o, mem_req, bus_error); end
    step();
    checks++; if (state_o !== 3'd7 || bus_error !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL wd_trap got st=%0d be=%b req=%b exp 7 1 0", state_o, bus_error, mem_req); end
    do_reset();
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1; opcode = ITYPE;
    step(); mem_ready = 1'b0; #1;
    checks++; if (state_o !== 3'd1 || bus_error !== 1'b0) begin errors++; $display("FAIL wd_ready_wins got st=%0d be=%b exp 1 0", state_o, bus_error); end
    rst = 1'b1; step(); rst = 1'b0; #1;
    checks++; if (state_o !== 3'd0 || bus_error !== 1'b0 || illegal_instr !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL final_reset got st=%0d be=%b ill=%b instret=%0d", state_o, bus_error, illegal_instr, instret); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
